bc_orbit_counter: RTL and testbench
===================================

Name: bc_orbit_counter

Overview:
- Parametrised bunch-crossing (BC) and orbit counter with BCR/ECR resynchronisation, BCR phase checking, lock detection and a saturating error counter.
- Sits in the timing front-end and distributes the BC ID and orbit number to data-tagging logic.
- Generalises the fixed 3564-slot counter with configurable modulus, widths, BCR offset and lock depth.

Parameters:
- LSB_CNT_MAX, 3564: BC slots per orbit; bc_cnt counts 0..LSB_CNT_MAX-1.
- LSB_W, 12: bc_cnt width; must satisfy 2^LSB_W >= LSB_CNT_MAX.
- MSB_W, 32: orbit_cnt width; wraps modulo 2^MSB_W.
- BCR_OFFSET, 0: bc_cnt value loaded on BCR; must be < LSB_CNT_MAX.
- LOCK_CNT, 2: consecutive phase-consistent BCRs (including the first) needed to lock; must be >= 1.
- MISS_MAX, 2: consecutive orbit wraps without BCR tolerated while LOCKED.
- ERR_W, 8: error counter width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; counters hold when low.
- bcr  in  1  bunch counter reset pulse.
- ecr  in  1  event/orbit counter reset pulse.
- err_clr  in  1  clears err_cnt.
- bc_cnt  out  LSB_W  current BC ID.
- orbit_cnt  out  MSB_W  current orbit number.
- orbit_strobe  out  1  one-cycle pulse when bc_cnt wraps to 0 naturally.
- locked  out  1  high in LOCKED state.
- bcr_err  out  1  one-cycle pulse on a phase error or a missed-BCR error.
- err_cnt  out  ERR_W  saturating error count.

Behaviour:
- All outputs are registered. rst (sync, high) sets every output to 0, the state to UNLOCKED, the match and miss counters to 0, and the first_bcr flag to 1. rst overrides all other inputs.
- Natural next value: nxt = (bc_cnt == LSB_CNT_MAX-1) ? 0 : bc_cnt+1.
- When en=1 and there is no bcr, bc_cnt <= nxt. On the wrap (bc_cnt == LSB_CNT_MAX-1 -> 0):
  - orbit_cnt increments, wrapping from 2^MSB_W-1 to 0;
  - orbit_strobe is 1 in the cycle after the wrap edge, i.e. when bc_cnt == 0.
- bcr (acts regardless of en):
  - bc_cnt <= BCR_OFFSET next cycle.
  - The BCR is aligned if nxt == BCR_OFFSET; otherwise it is misaligned.
  - A BCR-forced load is not a natural wrap, so it gives no orbit increment and no orbit_strobe.
- ecr (acts regardless of en): orbit_cnt <= 0 next cycle; this overrides a same-cycle natural increment. bcr and ecr together apply both effects.
- FSM, UNLOCKED:
  - First BCR after reset or after leaving LOCKED: match=1, first_bcr=0; phase is not judged.
  - Aligned BCR: match++.
  - Misaligned BCR: match=1 (re-phase), no error.
  - When match reaches LOCK_CNT, go to LOCKED with miss=0. With LOCK_CNT=1, the state becomes LOCKED the cycle after the first BCR.
- FSM, LOCKED:
  - Aligned BCR: miss=0, stay LOCKED.
  - Misaligned BCR: bcr_err pulse, err_cnt++, go to UNLOCKED with match=1 (this BCR re-phases).
  - Natural wrap without BCR in the same cycle: miss++. When miss reaches MISS_MAX: bcr_err pulse, err_cnt++, go to UNLOCKED with match=0 and first_bcr=1.
- err_cnt saturates at 2^ERR_W-1. err_clr sets it to 0. If err_clr and an error occur in the same cycle, the result is 1.
- bcr_err and the state change are visible the cycle after the triggering bcr or wrap.

Decomposition:
- Package bc_counter_pkg holds:
  - ZERO/TRUE constants;
  - the default LSB_CNT_MAX=3564;
  - typedef enum logic [0:0] {UNLOCKED, LOCKED} bc_lock_state_t;
  - a function bc_next(cnt, max) returning the natural next value.
- Sub-module mod_counter (parameters WIDTH, MODULUS; ports clk, rst, en, load, load_val, cnt, wrap) is instantiated twice: for bc_cnt, and for orbit_cnt with MODULUS = 2^MSB_W.
- The FSM, match/miss counters and error counter stay in the top module.

Test Plan:
- Free run (LSB_CNT_MAX=8, en=1, 20 cycles after rst) -> bc_cnt 0..7,0..7,0..3; orbit_cnt 0->1->2; orbit_strobe at bc_cnt==0 after each wrap; locked=0.
- Lock (LOCK_CNT=2, BCR_OFFSET=3, bcr when bc_cnt=5, then every 8 cycles) -> bc_cnt=3 after each bcr; locked=1 one cycle after the 2nd bcr; err_cnt=0.
- Phase error: while locked, bcr when bc_cnt=1 (nxt=2≠3) -> bc_cnt=3, bcr_err one pulse, err_cnt=1, locked=0. Next aligned bcr -> locked=1.
- Missed BCR (MISS_MAX=2): stop bcr while locked -> after 2nd wrap, bcr_err pulse, err_cnt+1, locked=0.
- ecr with a same-cycle natural wrap while orbit_cnt=5 -> orbit_cnt=0. bcr+ecr together -> bc_cnt=BCR_OFFSET and orbit_cnt=0. bcr with en=0 -> bc_cnt loads.
- ERR_W=2: force 5 errors -> err_cnt saturates at 3. err_clr together with an error -> err_cnt=1. rst mid-orbit while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bc_counter_pkg.sv
// Shared constants, lock-state type and next-value helper for the BC/orbit counter.
package bc_counter_pkg;

  localparam logic ZERO = 1'b0;
  localparam logic TRUE = 1'b1;

  localparam int unsigned LSB_CNT_MAX_DEFAULT = 3564;

  typedef enum logic [0:0] {UNLOCKED, LOCKED} bc_lock_state_t;

  function automatic logic [31:0] bc_next(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt == max - 32'd1) ? 32'd0 : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous load; wrap flags the cycle that rolls over to zero.
module mod_counter #(
  parameter int unsigned      WIDTH   = 12,
  parameter longint unsigned  MODULUS = 3564
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 64'd1);

  // Load has priority, so a forced load is never reported as a wrap.
  assign wrap = en && !load && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bc_orbit_counter.sv
// Bunch-crossing and orbit counter with BCR/ECR resync, BCR phase lock and error counting.
module bc_orbit_counter
  import bc_counter_pkg::*;
#(
  parameter int unsigned LSB_CNT_MAX = LSB_CNT_MAX_DEFAULT,
  parameter int unsigned LSB_W       = 12,
  parameter int unsigned MSB_W       = 32,
  parameter int unsigned BCR_OFFSET  = 0,
  parameter int unsigned LOCK_CNT    = 2,
  parameter int unsigned MISS_MAX    = 2,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bcr,
  input  logic             ecr,
  input  logic             err_clr,
  output logic [LSB_W-1:0] bc_cnt,
  output logic [MSB_W-1:0] orbit_cnt,
  output logic             orbit_strobe,
  output logic             locked,
  output logic             bcr_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned    MATCH_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int unsigned    MISS_W  = (MISS_MAX < 1) ? 1 : $clog2(MISS_MAX + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic             bc_wrap;
  logic             orbit_wrap;
  logic             unused_orbit_wrap;
  logic [31:0]      nxt_bc;
  logic             aligned;
  logic             miss_last;
  logic             err_ev;

  bc_lock_state_t   state_q;
  logic [MATCH_W-1:0] match_q;
  logic [MISS_W-1:0]  miss_q;
  logic             first_bcr_q;
  logic             strobe_q;
  logic             bcr_err_q;
  logic [ERR_W-1:0] err_cnt_q;

  mod_counter #(
    .WIDTH   (LSB_W),
    .MODULUS (64'(LSB_CNT_MAX))
  ) u_bc_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (bcr),
    .load_val (LSB_W'(BCR_OFFSET)),
    .cnt      (bc_cnt),
    .wrap     (bc_wrap)
  );

  // ECR is a load of zero, so it wins over a same-cycle increment.
  mod_counter #(
    .WIDTH   (MSB_W),
    .MODULUS (64'd1 << MSB_W)
  ) u_orbit_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (bc_wrap),
    .load     (ecr),
    .load_val ('0),
    .cnt      (orbit_cnt),
    .wrap     (orbit_wrap)
  );

  assign unused_orbit_wrap = orbit_wrap;

  assign nxt_bc    = bc_next(32'(bc_cnt), LSB_CNT_MAX);
  assign aligned   = (nxt_bc == BCR_OFFSET);
  assign miss_last = (32'(miss_q) + 32'd1) >= MISS_MAX;

  always_comb begin
    err_ev = ZERO;
    if (state_q == LOCKED) begin
      if (bcr) begin
        err_ev = !aligned;
      end else if (bc_wrap) begin
        err_ev = miss_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      match_q     <= '0;
      miss_q      <= '0;
      first_bcr_q <= TRUE;
      strobe_q    <= ZERO;
      bcr_err_q   <= ZERO;
      err_cnt_q   <= '0;
    end else begin
      strobe_q  <= bc_wrap;
      bcr_err_q <= err_ev;

      if (err_clr) begin
        err_cnt_q <= err_ev ? ERR_W'(1) : '0;
      end else if (err_ev && (err_cnt_q != ERR_MAX)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end

      unique case (state_q)
        UNLOCKED: begin
          if (bcr) begin
            first_bcr_q <= ZERO;
            // The first BCR and any misaligned one only set the phase reference.
            if (first_bcr_q || !aligned) begin
              match_q <= MATCH_W'(1);
              if (LOCK_CNT <= 1) begin
                state_q <= LOCKED;
                miss_q  <= '0;
              end
            end else begin
              match_q <= match_q + MATCH_W'(1);
              if ((32'(match_q) + 32'd1) >= LOCK_CNT) begin
                state_q <= LOCKED;
                miss_q  <= '0;
              end
            end
          end
        end
        LOCKED: begin
          if (bcr) begin
            if (aligned) begin
              miss_q <= '0;
            end else begin
              state_q     <= UNLOCKED;
              match_q     <= MATCH_W'(1);
              first_bcr_q <= ZERO;
            end
          end else if (bc_wrap) begin
            if (miss_last) begin
              state_q     <= UNLOCKED;
              match_q     <= '0;
              miss_q      <= '0;
              first_bcr_q <= TRUE;
            end else begin
              miss_q <= miss_q + MISS_W'(1);
            end
          end
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  end

  assign locked       = (state_q == LOCKED);
  assign orbit_strobe = strobe_q;
  assign bcr_err      = bcr_err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_bc_orbit_counter.sv
// Directed bench for bc_orbit_counter with an 8-slot orbit and hand-computed expectations.
module tb_bc_orbit_counter;

  localparam int unsigned LSB_CNT_MAX = 8;
  localparam int unsigned LSB_W       = 3;
  localparam int unsigned MSB_W       = 8;
  localparam int unsigned BCR_OFFSET  = 3;
  localparam int unsigned LOCK_CNT    = 2;
  localparam int unsigned MISS_MAX    = 2;
  localparam int unsigned ERR_W       = 2;

  logic             clk;
  logic             rst;
  logic             en;
  logic             bcr;
  logic             ecr;
  logic             err_clr;
  logic [LSB_W-1:0] bc_cnt;
  logic [MSB_W-1:0] orbit_cnt;
  logic             orbit_strobe;
  logic             locked;
  logic             bcr_err;
  logic [ERR_W-1:0] err_cnt;

  int n_cmp;
  int n_bad;

  bc_orbit_counter #(
    .LSB_CNT_MAX (LSB_CNT_MAX),
    .LSB_W       (LSB_W),
    .MSB_W       (MSB_W),
    .BCR_OFFSET  (BCR_OFFSET),
    .LOCK_CNT    (LOCK_CNT),
    .MISS_MAX    (MISS_MAX),
    .ERR_W       (ERR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .bcr          (bcr),
    .ecr          (ecr),
    .err_clr      (err_clr),
    .bc_cnt       (bc_cnt),
    .orbit_cnt    (orbit_cnt),
    .orbit_strobe (orbit_strobe),
    .locked       (locked),
    .bcr_err      (bcr_err),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic b, input logic e, input logic c);
    bcr = b; ecr = e; err_clr = c;
    step();
    bcr = 1'b0; ecr = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; en = 1'b0; bcr = 1'b0; ecr = 1'b0; err_clr = 1'b0;
    run(2);
    rst = 1'b0;
    check_eq("rst_bc", 32'(bc_cnt), 0);
    check_eq("rst_orbit", 32'(orbit_cnt), 0);
    check_eq("rst_strobe", 32'(orbit_strobe), 0);
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_err", 32'(err_cnt), 0);

    // Free run: 20 cycles.
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_eq("run_bc", 32'(bc_cnt), k % 8);
      check_eq("run_orbit", 32'(orbit_cnt), k / 8);
      check_eq("run_strobe", 32'(orbit_strobe), (k % 8 == 0) ? 1 : 0);
    end
    check_eq("run_locked", 32'(locked), 0);

    // Lock: first bcr at bc=5, second aligned one at bc=2.
    step();
    check_eq("pre_bcr_bc", 32'(bc_cnt), 5);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("bcr1_bc", 32'(bc_cnt), 3);
    check_eq("bcr1_locked", 32'(locked), 0);
    check_eq("bcr1_orbit", 32'(orbit_cnt), 2);
    run(7);
    check_eq("pre_bcr2_bc", 32'(bc_cnt), 2);
    check_eq("pre_bcr2_orbit", 32'(orbit_cnt), 3);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("bcr2_bc", 32'(bc_cnt), 3);
    check_eq("bcr2_locked", 32'(locked), 1);
    check_eq("bcr2_err", 32'(err_cnt), 0);

    // Phase error at bc=1.
    run(6);
    check_eq("pe_pre_bc", 32'(bc_cnt), 1);
    check_eq("pe_pre_locked", 32'(locked), 1);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("pe_bc", 32'(bc_cnt), 3);
    check_eq("pe_bcr_err", 32'(bcr_err), 1);
    check_eq("pe_err", 32'(err_cnt), 1);
    check_eq("pe_locked", 32'(locked), 0);
    step();
    check_eq("pe_bcr_err_pulse", 32'(bcr_err), 0);
    run(6);
    check_eq("relock_pre_bc", 32'(bc_cnt), 2);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("relock_locked", 32'(locked), 1);
    check_eq("relock_orbit", 32'(orbit_cnt), 5);

    // Missed BCRs: second wrap drops lock.
    run(12);
    check_eq("miss1_locked", 32'(locked), 1);
    check_eq("miss1_bcr_err", 32'(bcr_err), 0);
    step();
    check_eq("miss2_bc", 32'(bc_cnt), 0);
    check_eq("miss2_bcr_err", 32'(bcr_err), 1);
    check_eq("miss2_err", 32'(err_cnt), 2);
    check_eq("miss2_locked", 32'(locked), 0);
    check_eq("miss2_orbit", 32'(orbit_cnt), 7);

    // ECR with a same-cycle wrap.
    run(7);
    check_eq("ecr_pre_bc", 32'(bc_cnt), 7);
    pulse(1'b0, 1'b1, 1'b0);
    check_eq("ecr_bc", 32'(bc_cnt), 0);
    check_eq("ecr_orbit", 32'(orbit_cnt), 0);
    check_eq("ecr_strobe", 32'(orbit_strobe), 1);

    // BCR and ECR together.
    run(10);
    check_eq("be_pre_orbit", 32'(orbit_cnt), 1);
    pulse(1'b1, 1'b1, 1'b0);
    check_eq("be_bc", 32'(bc_cnt), 3);
    check_eq("be_orbit", 32'(orbit_cnt), 0);
    check_eq("be_strobe", 32'(orbit_strobe), 0);

    // BCR with en low still loads; en low otherwise holds.
    run(2);
    en = 1'b0;
    run(2);
    check_eq("hold_bc", 32'(bc_cnt), 5);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("en0_bcr_bc", 32'(bc_cnt), 3);
    en = 1'b1;

    // Saturation: lock, then a misaligned bcr right away, four times.
    for (int i = 0; i < 4; i++) begin
      run(7);
      pulse(1'b1, 1'b0, 1'b0);
      check_eq("sat_locked", 32'(locked), 1);
      pulse(1'b1, 1'b0, 1'b0);
      check_eq("sat_bcr_err", 32'(bcr_err), 1);
      check_eq("sat_err", 32'(err_cnt), 3);
    end

    // err_clr together with an error.
    run(7);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check_eq("clr_err_bcr_err", 32'(bcr_err), 1);
    check_eq("clr_err_cnt", 32'(err_cnt), 1);

    // Reset mid-orbit while locked.
    run(7);
    pulse(1'b1, 1'b0, 1'b0);
    run(2);
    check_eq("mid_bc", 32'(bc_cnt), 5);
    check_eq("mid_locked", 32'(locked), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst2_bc", 32'(bc_cnt), 0);
    check_eq("rst2_orbit", 32'(orbit_cnt), 0);
    check_eq("rst2_strobe", 32'(orbit_strobe), 0);
    check_eq("rst2_locked", 32'(locked), 0);
    check_eq("rst2_bcr_err", 32'(bcr_err), 0);
    check_eq("rst2_err", 32'(err_cnt), 0);
    step();
    check_eq("post_rst_bc", 32'(bc_cnt), 1);

    // err_clr alone after an error.
    run(6);
    pulse(1'b1, 1'b0, 1'b0);
    run(7);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("clr_pre_err", 32'(err_cnt), 1);
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("clr_only_err", 32'(err_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
